// File: rtl/ex_iter_alu.sv
// ex_iter_alu: execute-stage ALU with logic/shift ops, iterative multiply and
// divide (signed and unsigned), and architectural HI/LO registers.
// Single-cycle ops register their result one cycle after acceptance; mult/div
// iterate one bit per cycle and hold the upstream pipeline via stall_req_out.
module ex_iter_alu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_in,
  input  logic [3:0]        ex_alu_op_in,
  input  logic [DATA_W-1:0] ex_src1_in,
  input  logic [DATA_W-1:0] ex_src2_in,
  input  logic [ADDR_W-1:0] ex_des_addr_in,
  input  logic              ex_des_exist_in,
  input  logic              flush_in,
  output logic              ex_valid_out,
  output logic [ADDR_W-1:0] ex_des_addr_out,
  output logic              ex_des_exist_out,
  output logic [DATA_W-1:0] ex_des_data_out,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              stall_req_out
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [SH_W-1:0] LAST_CNT = SH_W'(DATA_W - 1);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_NOR   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_MULT  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_MFHI  = 4'd12;
  localparam logic [3:0] OP_MFLO  = 4'd13;
  localparam logic [3:0] OP_MTHI  = 4'd14;
  localparam logic [3:0] OP_MTLO  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  // FSM and iteration state
  state_t            r_state;
  state_t            w_state_next;
  logic [SH_W-1:0]   r_cnt;
  logic [SH_W-1:0]   w_cnt_next;

  // Architectural HI/LO
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] w_hi_next;
  logic [DATA_W-1:0] w_lo_next;

  // Iteration datapath: acc_hi is the partial product high half / remainder,
  // acc_lo is the multiplier shifting into the low product / quotient,
  // opnd is the multiplicand or divisor magnitude.
  logic [DATA_W-1:0] r_acc_hi;
  logic [DATA_W-1:0] r_acc_lo;
  logic [DATA_W-1:0] r_opnd;
  logic [DATA_W-1:0] r_dividend;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_div_zero;
  logic [DATA_W-1:0] w_acc_hi_next;
  logic [DATA_W-1:0] w_acc_lo_next;
  logic [DATA_W-1:0] w_opnd_next;
  logic [DATA_W-1:0] w_dividend_next;
  logic              w_neg_q_next;
  logic              w_neg_r_next;
  logic              w_div_zero_next;

  // Registered result
  logic              r_valid;
  logic              r_exist;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_valid_next;
  logic              w_exist_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic [DATA_W-1:0] w_data_next;
  logic              w_stall;

  // Decode and operand preparation
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_signed;
  logic              w_neg1;
  logic              w_neg2;
  logic [DATA_W-1:0] w_mag1;
  logic [DATA_W-1:0] w_mag2;
  logic [SH_W-1:0]   w_shamt;
  logic [DATA_W-1:0] w_result;
  logic              w_exist_ok;

  // Iteration step results
  logic [DATA_W:0]     w_mul_sum;
  logic [DATA_W-1:0]   w_mul_hi;
  logic [DATA_W-1:0]   w_mul_lo;
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W:0]     w_trial;
  logic                w_ge;
  logic [DATA_W-1:0]   w_div_rem;
  logic [DATA_W-1:0]   w_div_quo;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;

  assign w_is_mul = (ex_alu_op_in == OP_MULT) || (ex_alu_op_in == OP_MULTU);
  assign w_is_div = (ex_alu_op_in == OP_DIV)  || (ex_alu_op_in == OP_DIVU);
  assign w_signed = (ex_alu_op_in == OP_MULT) || (ex_alu_op_in == OP_DIV);
  assign w_neg1   = w_signed & ex_src1_in[DATA_W-1];
  assign w_neg2   = w_signed & ex_src2_in[DATA_W-1];
  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude 2^(DATA_W-1).
  assign w_mag1   = w_neg1 ? -ex_src1_in : ex_src1_in;
  assign w_mag2   = w_neg2 ? -ex_src2_in : ex_src2_in;
  assign w_shamt  = ex_src1_in[SH_W-1:0];

  // Ops that never write a GPR regardless of ex_des_exist_in
  assign w_exist_ok = ex_des_exist_in &&
                      !(ex_alu_op_in inside {OP_NOP, OP_MTHI, OP_MTLO,
                                             OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift {carry, hi, lo} right by one.
  assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_hi   = w_mul_sum[DATA_W:1];
  assign w_mul_lo   = {w_mul_sum[0], r_acc_lo[DATA_W-1:1]};
  assign w_prod     = {w_mul_hi, w_mul_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  // Restoring division step: bring down the next dividend bit and subtract
  // the divisor if it fits.
  assign w_trial   = {r_acc_hi, r_acc_lo[DATA_W-1]} - {1'b0, r_opnd};
  assign w_ge      = !w_trial[DATA_W];
  assign w_div_rem = w_ge ? w_trial[DATA_W-1:0] : {r_acc_hi[DATA_W-2:0], r_acc_lo[DATA_W-1]};
  assign w_div_quo = {r_acc_lo[DATA_W-2:0], w_ge};
  assign w_quo_fix = r_neg_q ? -w_div_quo : w_div_quo;
  assign w_rem_fix = r_neg_r ? -w_div_rem : w_div_rem;

  // Single-cycle result selection
  always_comb begin
    w_result = '0;
    case (ex_alu_op_in)
      OP_OR:   w_result = ex_src1_in | ex_src2_in;
      OP_AND:  w_result = ex_src1_in & ex_src2_in;
      OP_NOR:  w_result = ~(ex_src1_in | ex_src2_in);
      OP_XOR:  w_result = ex_src1_in ^ ex_src2_in;
      OP_SLL:  w_result = ex_src2_in << w_shamt;
      OP_SRL:  w_result = ex_src2_in >> w_shamt;
      OP_SRA:  w_result = $signed(ex_src2_in) >>> w_shamt;
      OP_MFHI: w_result = r_hi;
      OP_MFLO: w_result = r_lo;
      default: w_result = '0;
    endcase
  end

  // Next-state, datapath and output decode; flush overrides everything
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_hi_next       = r_hi;
    w_lo_next       = r_lo;
    w_acc_hi_next   = r_acc_hi;
    w_acc_lo_next   = r_acc_lo;
    w_opnd_next     = r_opnd;
    w_dividend_next = r_dividend;
    w_neg_q_next    = r_neg_q;
    w_neg_r_next    = r_neg_r;
    w_div_zero_next = r_div_zero;
    w_valid_next    = 1'b0;
    w_exist_next    = 1'b0;
    w_addr_next     = '0;
    w_data_next     = '0;
    w_stall         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (ex_valid_in) begin
          if (w_is_mul || w_is_div) begin
            w_stall         = 1'b1;
            w_state_next    = w_is_mul ? S_MUL : S_DIV;
            w_cnt_next      = '0;
            w_acc_hi_next   = '0;
            w_neg_q_next    = w_neg1 ^ w_neg2;
            w_neg_r_next    = w_neg1;
            w_div_zero_next = (ex_src2_in == '0);
            w_dividend_next = ex_src1_in;
            if (w_is_mul) begin
              w_opnd_next   = w_mag1;
              w_acc_lo_next = w_mag2;
            end else begin
              w_opnd_next   = w_mag2;
              w_acc_lo_next = w_mag1;
            end
          end else begin
            w_valid_next = 1'b1;
            w_addr_next  = ex_des_addr_in;
            w_exist_next = w_exist_ok;
            w_data_next  = w_result;
            if (ex_alu_op_in == OP_MTHI) w_hi_next = ex_src1_in;
            if (ex_alu_op_in == OP_MTLO) w_lo_next = ex_src1_in;
          end
        end
      end
      S_MUL: begin
        w_acc_hi_next = w_mul_hi;
        w_acc_lo_next = w_mul_lo;
        w_cnt_next    = r_cnt + SH_W'(1);
        if (r_cnt == LAST_CNT) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_valid_next = 1'b1;
          w_hi_next    = w_prod_fix[2*DATA_W-1:DATA_W];
          w_lo_next    = w_prod_fix[DATA_W-1:0];
        end else begin
          w_stall = 1'b1;
        end
      end
      S_DIV: begin
        w_acc_hi_next = w_div_rem;
        w_acc_lo_next = w_div_quo;
        w_cnt_next    = r_cnt + SH_W'(1);
        if (r_cnt == LAST_CNT) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_valid_next = 1'b1;
          if (r_div_zero) begin
            w_hi_next = r_dividend;
            w_lo_next = '1;
          end else begin
            w_hi_next = w_rem_fix;
            w_lo_next = w_quo_fix;
          end
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase

    if (flush_in) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_hi_next    = r_hi;
      w_lo_next    = r_lo;
      w_valid_next = 1'b0;
      w_exist_next = 1'b0;
      w_addr_next  = '0;
      w_data_next  = '0;
      w_stall      = 1'b0;
    end
  end

  // FSM state and iteration counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // HI/LO, iteration datapath and registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_opnd     <= '0;
      r_dividend <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_valid    <= 1'b0;
      r_exist    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_hi       <= w_hi_next;
      r_lo       <= w_lo_next;
      r_acc_hi   <= w_acc_hi_next;
      r_acc_lo   <= w_acc_lo_next;
      r_opnd     <= w_opnd_next;
      r_dividend <= w_dividend_next;
      r_neg_q    <= w_neg_q_next;
      r_neg_r    <= w_neg_r_next;
      r_div_zero <= w_div_zero_next;
      r_valid    <= w_valid_next;
      r_exist    <= w_exist_next;
      r_addr     <= w_addr_next;
      r_data     <= w_data_next;
    end
  end

  assign ex_valid_out     = r_valid;
  assign ex_des_exist_out = r_exist;
  assign ex_des_addr_out  = r_addr;
  assign ex_des_data_out  = r_data;
  assign hi_out           = r_hi;
  assign lo_out           = r_lo;
  // Held low while in reset so the upstream pipeline is never frozen by a
  // decode of inputs that the reset state is about to ignore.
  assign stall_req_out    = w_stall & rst;

endmodule

// File: tb/tb_ex_iter_alu.sv
// tb_ex_iter_alu: directed plus randomized checks of ex_iter_alu against an
// arithmetic reference model of the op set and HI/LO state.
module tb_ex_iter_alu;
  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid_in;
  logic [3:0]    ex_alu_op_in;
  logic [W-1:0]  ex_src1_in;
  logic [W-1:0]  ex_src2_in;
  logic [AW-1:0] ex_des_addr_in;
  logic          ex_des_exist_in;
  logic          flush_in;
  logic          ex_valid_out;
  logic [AW-1:0] ex_des_addr_out;
  logic          ex_des_exist_out;
  logic [W-1:0]  ex_des_data_out;
  logic [W-1:0]  hi_out;
  logic [W-1:0]  lo_out;
  logic          stall_req_out;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  ex_iter_alu #(.DATA_W(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_in(ex_valid_in), .ex_alu_op_in(ex_alu_op_in),
    .ex_src1_in(ex_src1_in), .ex_src2_in(ex_src2_in),
    .ex_des_addr_in(ex_des_addr_in), .ex_des_exist_in(ex_des_exist_in),
    .flush_in(flush_in),
    .ex_valid_out(ex_valid_out), .ex_des_addr_out(ex_des_addr_out),
    .ex_des_exist_out(ex_des_exist_out), .ex_des_data_out(ex_des_data_out),
    .hi_out(hi_out), .lo_out(lo_out), .stall_req_out(stall_req_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: result of one op, updating model HI/LO
  task automatic ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res);
    int           sh;
    int           sa;
    int           sb;
    longint       pa;
    longint       pb;
    logic [63:0]  u;
    logic [W-1:0] ones;
    ones = '1;
    sh   = int'(a[4:0]);
    res  = '0;
    case (op)
      4'd1: res = a | b;
      4'd2: res = a & b;
      4'd3: res = ~(a | b);
      4'd4: res = a ^ b;
      4'd5: res = b << sh;
      4'd6: res = b >> sh;
      4'd7: begin
        res = b >> sh;
        if (b[W-1]) res = res | ~(ones >> sh);
      end
      4'd8: begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        u  = 64'(pa * pb);
        {m_hi, m_lo} = u;
      end
      4'd9: begin
        u = {32'b0, a} * {32'b0, b};
        {m_hi, m_lo} = u;
      end
      4'd10: begin
        if (b == 0) begin
          m_lo = ones; m_hi = a;
        end else if (a == 32'h8000_0000 && b == ones) begin
          m_lo = 32'h8000_0000; m_hi = '0;
        end else begin
          sa = a; sb = b;
          m_lo = sa / sb;
          m_hi = sa % sb;
        end
      end
      4'd11: begin
        if (b == 0) begin
          m_lo = ones; m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      4'd12: res = m_hi;
      4'd13: res = m_lo;
      4'd14: m_hi = a;
      4'd15: m_lo = a;
      default: res = '0;
    endcase
  endtask

  // Present one instruction (starting 1 time unit after a rising edge), hold
  // it while stalled, then check the registered result and HI/LO.
  task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [AW-1:0] addr, input logic ex);
    logic [W-1:0] exp_res;
    bit           multi;
    bit           wr;
    int           n;
    multi = (op >= 4'd8 && op <= 4'd11);
    wr    = ex && !(op == 4'd0 || op == 4'd14 || op == 4'd15 || multi);
    ex_valid_in = 1'b1; ex_alu_op_in = op; ex_src1_in = a; ex_src2_in = b;
    ex_des_addr_in = addr; ex_des_exist_in = ex;
    #1;
    n = 0;
    while (stall_req_out && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    ref_op(op, a, b, exp_res);
    check($sformatf("%s stall_cycles", tag), 64'(n), multi ? 64'(W) : 64'd0);
    @(posedge clk); #1;
    ex_valid_in = 1'b0;
    check($sformatf("%s valid", tag), 64'(ex_valid_out), 64'd1);
    check($sformatf("%s exist", tag), 64'(ex_des_exist_out), 64'(wr));
    check($sformatf("%s data", tag), 64'(ex_des_data_out), multi ? 64'd0 : 64'(exp_res));
    if (!multi) check($sformatf("%s addr", tag), 64'(ex_des_addr_out), 64'(addr));
    check($sformatf("%s hi", tag), 64'(hi_out), 64'(m_hi));
    check($sformatf("%s lo", tag), 64'(lo_out), 64'(m_lo));
    $display("op %0d src1=0x%08h src2=0x%08h -> data=0x%08h hi=0x%08h lo=0x%08h stall=%0d [%s]",
             op, a, b, ex_des_data_out, hi_out, lo_out, n, tag);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b0; ex_valid_in = 1'b0; ex_alu_op_in = '0; ex_src1_in = '0; ex_src2_in = '0;
    ex_des_addr_in = '0; ex_des_exist_in = 1'b0; flush_in = 1'b0;
    #1;
    check("reset valid", 64'(ex_valid_out), 0);
    check("reset data", 64'(ex_des_data_out), 0);
    check("reset hi", 64'(hi_out), 0);
    check("reset lo", 64'(lo_out), 0);
    check("reset stall", 64'(stall_req_out), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("idle valid", 64'(ex_valid_out), 0);
    check("idle exist", 64'(ex_des_exist_out), 0);

    // directed
    issue("or", 4'd1, 32'h0F0F_0000, 32'h0000_00F0, 5'd3, 1'b1);
    check("or const", 64'(ex_des_data_out), 64'h0F0F_00F0);
    issue("sra4", 4'd7, 32'd4, 32'h8000_0000, 5'd4, 1'b1);
    check("sra4 const", 64'(ex_des_data_out), 64'hF800_0000);
    issue("sra0", 4'd7, 32'd0, 32'h8000_0000, 5'd5, 1'b1);
    check("sra0 const", 64'(ex_des_data_out), 64'h8000_0000);
    issue("srl31", 4'd6, 32'd31, 32'h8000_0000, 5'd6, 1'b1);
    check("srl31 const", 64'(ex_des_data_out), 64'h1);
    @(posedge clk); #1;
    check("idle2 valid", 64'(ex_valid_out), 0);
    check("idle2 data", 64'(ex_des_data_out), 0);

    issue("mult", 4'd8, -32'sd3, 32'd5, 5'd7, 1'b1);
    check("mult hi const", 64'(hi_out), 64'hFFFF_FFFF);
    check("mult lo const", 64'(lo_out), 64'hFFFF_FFF1);
    @(posedge clk); #1;
    check("mult single pulse", 64'(ex_valid_out), 0);
    issue("mflo", 4'd13, 32'd0, 32'd0, 5'd8, 1'b1);
    check("mflo const", 64'(ex_des_data_out), 64'hFFFF_FFF1);
    issue("divu", 4'd11, 32'd100, 32'd7, 5'd1, 1'b1);
    check("divu lo const", 64'(lo_out), 64'd14);
    check("divu hi const", 64'(hi_out), 64'd2);
    issue("div", 4'd10, -32'sd7, 32'd2, 5'd1, 1'b1);
    check("div lo const", 64'(lo_out), 64'hFFFF_FFFD);
    check("div hi const", 64'(hi_out), 64'hFFFF_FFFF);
    issue("div0", 4'd10, 32'd5, 32'd0, 5'd1, 1'b1);
    check("div0 lo const", 64'(lo_out), 64'hFFFF_FFFF);
    check("div0 hi const", 64'(hi_out), 64'd5);
    issue("divmin", 4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 1'b1);
    issue("mthi", 4'd14, 32'h1234, 32'd0, 5'd9, 1'b1);
    issue("mfhi", 4'd12, 32'd0, 32'd0, 5'd10, 1'b1);
    check("mfhi const", 64'(ex_des_data_out), 64'h1234);
    check("mfhi addr const", 64'(ex_des_addr_out), 64'd10);

    // randomized
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      issue($sformatf("rand%0d", i), op, pick(), pick(), 5'($urandom), 1'($urandom));
    end

    // flush mid-multu at busy cycle 10
    issue("pre_flush_mthi", 4'd14, 32'hA5A5_0001, 32'd0, 5'd2, 1'b0);
    issue("pre_flush_mtlo", 4'd15, 32'h5A5A_0002, 32'd0, 5'd2, 1'b0);
    ex_valid_in = 1'b1; ex_alu_op_in = 4'd9; ex_src1_in = 32'd1234; ex_src2_in = 32'd5678;
    #1;
    repeat (11) begin @(posedge clk); #1; end
    check("flush busy stall", 64'(stall_req_out), 1);
    flush_in = 1'b1;
    #1;
    check("flush stall drop", 64'(stall_req_out), 0);
    @(posedge clk); #1;
    flush_in = 1'b0; ex_valid_in = 1'b0;
    check("flush valid", 64'(ex_valid_out), 0);
    check("flush hi", 64'(hi_out), 64'(m_hi));
    check("flush lo", 64'(lo_out), 64'(m_lo));
    #1;
    check("flush idle stall", 64'(stall_req_out), 0);
    issue("post_flush_xor", 4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd11, 1'b1);
    issue("post_flush_multu", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1);

    // reset mid-divide
    ex_valid_in = 1'b1; ex_alu_op_in = 4'd10; ex_src1_in = 32'd999; ex_src2_in = 32'd3;
    ex_des_addr_in = 5'd12; ex_des_exist_in = 1'b1;
    #1;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("rst valid", 64'(ex_valid_out), 0);
    check("rst exist", 64'(ex_des_exist_out), 0);
    check("rst addr", 64'(ex_des_addr_out), 0);
    check("rst data", 64'(ex_des_data_out), 0);
    check("rst hi", 64'(hi_out), 0);
    check("rst lo", 64'(lo_out), 0);
    check("rst stall", 64'(stall_req_out), 0);
    ex_valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue("post_rst_mfhi", 4'd12, 32'd0, 32'd0, 5'd13, 1'b1);
    issue("post_rst_divu", 4'd11, 32'd1000, 32'd33, 5'd13, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_iter_alu.md
# ex_iter_alu

Parametrised execute-stage unit that replaces the single-cycle logic/shift ALU. It adds a correct arithmetic right shift, iterative signed and unsigned multiply and divide, and architectural HI/LO registers with move-to and move-from operations. It sits between the ID/EX and EX/MEM pipeline registers. Results are registered, and `stall_req_out` freezes the upstream pipeline while a multi-cycle operation runs.

## Interface
- `DATA_W`, default 32: operand/result width; power of two, ≥8. `SH_W = $clog2(DATA_W)`.
- `ADDR_W`, default 5: destination register address width.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ex_valid_in` in 1: an instruction is present on the inputs.
- `ex_alu_op_in` in 4: operation code:
  - 0 nop, 1 or, 2 and, 3 nor, 4 xor, 5 sll, 6 srl, 7 sra
  - 8 mult, 9 multu, 10 div, 11 divu
  - 12 mfhi, 13 mflo, 14 mthi, 15 mtlo
- `ex_src1_in` in DATA_W: operand 1; shift amount is `[SH_W-1:0]`; dividend; mthi/mtlo source.
- `ex_src2_in` in DATA_W: operand 2; value to shift; divisor.
- `ex_des_addr_in` in ADDR_W: destination register address.
- `ex_des_exist_in` in 1: instruction writes a GPR.
- `flush_in` in 1: abort the current instruction and any iteration in progress.
- `ex_valid_out` out 1: a registered result is valid this cycle.
- `ex_des_addr_out` out ADDR_W: registered destination address.
- `ex_des_exist_out` out 1: registered GPR write enable.
- `ex_des_data_out` out DATA_W: registered result.
- `hi_out`, `lo_out` out DATA_W: current HI/LO register contents.
- `stall_req_out` out 1: combinational; upstream must hold its inputs while this is high.

## Operation
- **States:** IDLE, MUL, DIV. Iteration counter is SH_W bits wide.
- **Single-cycle ops** (0–7, 12–15), in IDLE with `ex_valid_in` high and `flush_in` low:
  - or/and/nor/xor: bitwise on src1, src2.
  - sll/srl: src2 shifted by the shift amount.
  - sra: arithmetic right shift, sign bit replicated; shift amount 0 returns src2 unchanged.
  - mfhi/mflo: result = HI / LO.
  - mthi/mtlo: HI / LO ← src1; result 0.
  - nop: result 0.
- **Write-enable:** `ex_des_exist_out` = `ex_des_exist_in`, except forced to 0 for nop, mthi, mtlo, mult, multu, div and divu.
- **Multi-cycle accept:** mult/multu/div/divu in IDLE with valid and no flush is accepted.
  - Operand magnitudes (signed ops) or raw operands (unsigned ops) are captured.
  - The result sign is captured, the counter is cleared, and the FSM moves to MUL or DIV.
- **MUL:** shift-add, one bit per cycle, for DATA_W cycles. {HI,LO} ← 2·DATA_W-bit product, sign-corrected.
- **DIV:** restoring division, one quotient bit per cycle, for DATA_W cycles. LO ← quotient, HI ← remainder.
  - Signed: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Divisor zero: LO = all ones, HI = src1. Latency is unchanged.
  - Signed MIN / −1: LO = MIN, HI = 0.
- **Completion:** on the edge where the counter equals DATA_W−1, HI/LO are written, the FSM returns to IDLE, and `ex_valid_out` pulses with exist = 0 and data = 0.
- **While busy:** inputs are ignored except `flush_in`.
- **Idle output:** with no accepted instruction, the next cycle has `ex_valid_out`, exist, addr and data all 0.
- **flush_in:** dominates every other input.
  - The FSM goes to IDLE and the counter is cleared.
  - HI/LO are unchanged.
  - Next cycle `ex_valid_out` is 0.

## Timing
- **Reset:** all outputs, HI, LO and the counter are 0; FSM is IDLE; `stall_req_out` is 0.
- **Single-cycle latency:** result is visible 1 cycle after acceptance.
- **stall_req_out** = `!flush_in & ((IDLE & ex_valid_in & op∈{8..11}) | (MUL|DIV & cnt≠DATA_W−1))`.
  - It is high for exactly DATA_W consecutive cycles: the accept cycle plus the first DATA_W−1 busy cycles.
  - It is low in the final iteration cycle, so the pipeline advances on that edge. The next instruction is seen in IDLE, and the same multiply/divide is never re-accepted.
- **HI/LO after multi-cycle ops:** valid DATA_W cycles after the accept edge. An mfhi presented in the cycle after completion reads the new value.
- **HI/LO after mthi/mtlo:** visible to an mfhi/mflo in the immediately following cycle.
- **Reset mid-operation:** asynchronous; takes effect immediately; no partial HI/LO write.

## Test plan
- **Logic and shift (DATA_W=32):**
  - or 0x0F0F0000 | 0x00F0 → 0x0F0F00F0.
  - sra of 0x80000000 by 4 → 0xF8000000.
  - sra of 0x80000000 by 0 → 0x80000000.
  - srl of 0x80000000 by 31 → 0x00000001.
  - Each with `ex_valid_out` high one cycle later and exist passed through.
- **mult −3×5:**
  - `stall_req_out` high for exactly 32 cycles.
  - Then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1, with a single `ex_valid_out` pulse with exist = 0.
  - A following mflo returns 0xFFFFFFF1.
- **divu 100/7:** LO = 14, HI = 2.
- **div −7/2:** LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- **div 5/0:** LO = 0xFFFFFFFF, HI = 5, after the full 32-cycle latency.
- **mthi 0x1234 then mfhi back-to-back:** mfhi result is 0x1234 with the mfhi's destination address.
- **Flush and reset mid-operation:**
  - flush_in asserted at busy cycle 10 of a multu: stall drops the same cycle, HI/LO keep their prior values, and the next op executes normally.
  - rst low mid-div: all outputs are 0 immediately.
